// File: rtl/rtc_hms_counter.sv
// Hours/minutes/seconds wall-clock counter with prescaler, validated load,
// 12/24-hour display, rollover strobes and an hh:mm alarm.
module rtc_hms_counter #(
    parameter int TICK_DIV = 50000000,
    parameter bit ALARM_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [4:0] ld_hr,
    input  logic [5:0] ld_min,
    input  logic [5:0] ld_sec,
    input  logic       mode12,
    input  logic       al_set,
    input  logic       al_clr,
    input  logic [4:0] al_hr,
    input  logic [5:0] al_min,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic [4:0] hr_disp,
    output logic       pm,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       hr_tick,
    output logic       day_tick,
    output logic       load_err,
    output logic       alarm_armed,
    output logic       alarm_hit
);
    localparam int PCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PCW-1:0] PC_MAX = PCW'(TICK_DIV - 1);

    logic [PCW-1:0] pc;
    logic           adv, ld_ok, ld_go, adv_go;
    logic           c_min, c_hr, c_day;
    logic [5:0]     nsec, nmin;
    logic [4:0]     nhr;

    assign adv    = en && (pc == PC_MAX);
    assign ld_ok  = (ld_hr <= 5'd23) && (ld_min <= 6'd59) && (ld_sec <= 6'd59);
    assign ld_go  = load && ld_ok;
    assign adv_go = adv && !ld_go;

    // Next time value if this cycle advances; carries ripple sec -> min -> hr.
    always_comb begin
        c_min = (sec == 6'd59);
        c_hr  = c_min && (min == 6'd59);
        c_day = c_hr && (hr == 5'd23);
        nsec  = c_min ? 6'd0 : sec + 6'd1;
        nmin  = c_hr ? 6'd0 : (c_min ? min + 6'd1 : min);
        nhr   = c_day ? 5'd0 : (c_hr ? hr + 5'd1 : hr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= '0;
            sec      <= '0;
            min      <= '0;
            hr       <= '0;
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            hr_tick  <= 1'b0;
            day_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_err <= load && !ld_ok;
            if (ld_go) begin
                pc       <= '0;
                sec      <= ld_sec;
                min      <= ld_min;
                hr       <= ld_hr;
                sec_tick <= 1'b0;
                min_tick <= 1'b0;
                hr_tick  <= 1'b0;
                day_tick <= 1'b0;
            end else begin
                if (en) pc <= adv ? '0 : pc + PCW'(1);
                sec_tick <= adv;
                min_tick <= adv && c_min;
                hr_tick  <= adv && c_hr;
                day_tick <= adv && c_day;
                if (adv) begin
                    sec <= nsec;
                    min <= nmin;
                    hr  <= nhr;
                end
            end
        end
    end

    always_comb begin
        pm      = (hr >= 5'd12);
        hr_disp = hr;
        if (mode12) begin
            if (hr == 5'd0)       hr_disp = 5'd12;
            else if (hr > 5'd12)  hr_disp = hr - 5'd12;
        end
    end

    generate
        if (ALARM_EN) begin : g_alarm
            logic [4:0] al_hr_r;
            logic [5:0] al_min_r;
            logic       armed, hit;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    al_hr_r  <= '0;
                    al_min_r <= '0;
                    armed    <= 1'b0;
                    hit      <= 1'b0;
                end else begin
                    if (al_set) begin
                        al_hr_r  <= al_hr;
                        al_min_r <= al_min;
                    end
                    if (al_clr)      armed <= 1'b0;
                    else if (al_set) armed <= 1'b1;
                    // Only an advance can hit; a load onto the alarm time stays silent.
                    hit <= armed && adv_go && (nsec == 6'd0) &&
                           (nmin == al_min_r) && (nhr == al_hr_r);
                end
            end
            assign alarm_armed = armed;
            assign alarm_hit   = hit;
        end else begin : g_no_alarm
            assign alarm_armed = 1'b0;
            assign alarm_hit   = 1'b0;
        end
    endgenerate
endmodule

// File: doc/rtc_hms_counter.md
Name: rtc_hms_counter

Overview:
Parametrised hours/minutes/seconds real-time counter, the successor to the team's fixed sec/min/hr counter. It adds a built-in prescaler, an enable, a validated synchronous time load, a 12/24-hour display mode, one-cycle rollover strobes and an hh:mm alarm. It sits between the system clock domain and display/control logic and is the single source of wall-clock time in the design.

Parameters:
TICK_DIV, 50000000, clk cycles per second; legal range >= 1; 1 means advance every enabled cycle.
ALARM_EN, 1, 1 builds the alarm logic; 0 ties alarm_hit and alarm_armed to 0.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
en  in  1  count enable; 0 freezes prescaler and time
load  in  1  one-cycle request to load ld_hr/ld_min/ld_sec
ld_hr  in  5  load hours, 0-23
ld_min  in  6  load minutes, 0-59
ld_sec  in  6  load seconds, 0-59
mode12  in  1  1 selects 12-hour display on hr_disp/pm
al_set  in  1  one-cycle strobe capturing al_hr/al_min and arming the alarm
al_clr  in  1  one-cycle strobe disarming the alarm
al_hr  in  5  alarm hours, 0-23
al_min  in  6  alarm minutes, 0-59
sec  out  6  seconds 0-59
min  out  6  minutes 0-59
hr  out  5  hours 0-23, always 24-hour
hr_disp  out  5  hr, or 1-12 when mode12=1
pm  out  1  1 when hr >= 12, independent of mode12
sec_tick  out  1  one-cycle strobe, seconds advanced this cycle
min_tick  out  1  one-cycle strobe, 59->0 seconds wrap
hr_tick  out  1  one-cycle strobe, 59->0 minutes wrap
day_tick  out  1  one-cycle strobe, 23:59:59 -> 00:00:00
load_err  out  1  one-cycle strobe, load rejected
alarm_armed  out  1  alarm is armed
alarm_hit  out  1  one-cycle strobe on alarm match

Behaviour:
- Reset (async on rst rise, held while high): prescaler=0; sec/min/hr=0; all strobes 0; alarm_armed=0; alarm regs=0; hr_disp is 0 if mode12=0, otherwise 12; pm=0.
- Prescaler pc counts 0..TICK_DIV-1 while en=1. Advance condition: en=1 and pc==TICK_DIV-1, after which pc returns to 0. With en=0, pc, time and all strobes hold, and strobes are 0.
- On advance: sec+1. At sec 59: sec=0 and min+1. At min 59 with that carry: min=0 and hr+1. At hr 23 with that carry: hr=0. Wrap limits are 59/59/23, never 60.
- Strobes are registered and assert in the same cycle the new time value first appears on the outputs. sec_tick fires on every advance. min_tick, hr_tick and day_tick fire only on their carries. At 23:59:59 -> 0 all four assert together.
- First advance occurs TICK_DIV cycles after reset release with en=1. TICK_DIV=1: advances every enabled cycle.
- Load (load=1): with all ld fields in range, time takes ld values next cycle, pc=0, and no strobes fire that cycle. Load has priority over a coincident advance, which is dropped. Any field out of range: time and pc unchanged, load_err=1 for one cycle, and a coincident advance proceeds normally. Load is accepted regardless of en.
- Display: with mode12=0, hr_disp=hr. With mode12=1: hr 0 gives 12, hr 1-12 gives hr, hr 13-23 gives hr-12. hr_disp and pm are combinational from hr and mode12.
- Alarm (ALARM_EN=1): al_set captures al_hr/al_min and sets alarm_armed. Out-of-range alarm values are captured but can never match. al_clr clears alarm_armed. al_set and al_clr together: al_clr wins.
- alarm_hit=1 for one cycle when an advance makes the time equal al_hr:al_min:00 while armed. A load landing exactly on the alarm time does not fire. alarm_armed stays set after a hit, so the alarm re-fires daily.
- Reset asserted mid-operation aborts everything immediately; a pending load or al_set is lost.

Test Plan:
- TICK_DIV=4, rst release, en=1 -> sec_tick first at cycle 4, then every 4 cycles; sec counts 0..59, then 0 with min_tick=1 and min=1.
- Load 23:59:58, TICK_DIV=1 -> after 2 advances time is 00:00:00 with sec/min/hr/day_tick all 1 in the same cycle; pm goes 1->0.
- Load ld_min=60 -> load_err=1 for one cycle, time unchanged. Load 12:30:00 coincident with an advance -> time 12:30:00, no sec_tick.
- mode12=1 at hr 0, 12 and 13 -> hr_disp 12, 12 and 1; pm 0, 1 and 1.
- al_set 07:15, load 07:14:59, advance -> alarm_hit one cycle at 07:15:00. al_clr then repeat -> no hit. Load 07:15:00 directly -> no hit.
- en=0 for 10 cycles mid-count -> sec and pc frozen, no strobes. rst pulse mid-count -> all outputs 0 asynchronously, alarm_armed=0.
